// File: rtl/loader_pkg.sv
// Shared types and constants for the UART-driven DMA image loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StAck
  } state_e;

  localparam logic [7:0]  MagicDefault = 8'hA5;
  localparam int unsigned HdrLen       = 6;
  localparam logic [3:0]  ByteEnAll    = 4'b1111;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte word assembler with a running mod-256 checksum.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_frame_i,
  input  logic        clear_word_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [2:0]  count_o,
  output logic        full_o,
  output logic [7:0]  checksum_o
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    if (clear_frame_i) begin
      word_d = '0;
      cnt_d  = '0;
      sum_d  = '0;
    end else if (clear_word_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (push_i && (cnt_q != 3'd4)) begin
      // First byte received ends up in bits [7:0] once four bytes are in.
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 3'd1;
      sum_d  = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
    end
  end

  assign word_o     = word_q;
  assign count_o    = cnt_q;
  assign full_o     = (cnt_q == 3'd4);
  assign checksum_o = sum_q;

endmodule

// File: rtl/uart_dma_loader.sv
// Receives a framed image over the UART byte stream, writes it word by word through
// the DMA port and answers with a one-byte payload checksum.
module uart_dma_loader
  import loader_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  MAGIC          = MagicDefault
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_valid,
  output logic            o_rx_ready,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_req_dma,
  input  logic            i_gnt_dma,
  output logic [XLEN-1:0] o_dma_addr,
  output logic            o_dma_write,
  output logic            o_dma_read,
  output logic [3:0]      o_dma_size,
  output logic [XLEN-1:0] o_dma_din,
  input  logic [XLEN-1:0] i_dma_dout,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_error
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic              rx_fire;
  logic              tmo_hit;
  logic              clear_frame, clear_word, push;
  logic [31:0]       pk_word;
  logic [2:0]        pk_count;
  logic              pk_full;
  logic [7:0]        pk_sum;
  logic              unused_sigs;

  byte_packer u_packer (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .clear_frame_i (clear_frame),
    .clear_word_i  (clear_word),
    .push_i        (push),
    .byte_i        (i_rx_data),
    .word_o        (pk_word),
    .count_o       (pk_count),
    .full_o        (pk_full),
    .checksum_o    (pk_sum)
  );

  assign rx_fire = i_rx_valid && o_rx_ready;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    o_rx_ready  = 1'b0;
    o_tx_valid  = 1'b0;
    o_req_dma   = 1'b0;
    o_dma_write = 1'b0;
    o_dma_size  = 4'b0000;
    o_done      = 1'b0;
    o_error     = 1'b0;
    clear_frame = 1'b0;
    clear_word  = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      StIdle: begin
        o_rx_ready = i_enable;
        if (rx_fire && (i_rx_data == MAGIC)) begin
          state_d     = StHdr;
          hdr_cnt_d   = '0;
          tmo_d       = '0;
          clear_frame = 1'b1;
        end
      end
      StHdr: begin
        o_rx_ready = 1'b1;
        if (rx_fire) begin
          tmo_d     = '0;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q < 3'd4) begin
            addr_d = {i_rx_data, addr_q[XLEN-1:8]};
            if (hdr_cnt_q == 3'd3) addr_d[1:0] = 2'b00;
          end else begin
            rem_d = {i_rx_data, rem_q[15:8]};
          end
          if (hdr_cnt_q == 3'(HdrLen - 1)) begin
            state_d = ({i_rx_data, rem_q[15:8]} == 16'h0000) ? StAck : StData;
          end
        end else if (tmo_hit) begin
          o_error = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StData: begin
        o_rx_ready = 1'b1;
        if (rx_fire) begin
          tmo_d = '0;
          push  = 1'b1;
          if (pk_count == 3'd3) state_d = StWrite;
        end else if (tmo_hit) begin
          o_error    = 1'b1;
          clear_word = 1'b1;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWrite: begin
        o_req_dma   = 1'b1;
        o_dma_write = 1'b1;
        o_dma_size  = ByteEnAll;
        if (i_gnt_dma) begin
          clear_word = 1'b1;
          addr_d     = addr_q + XLEN'(4);
          rem_d      = rem_q - 16'd1;
          tmo_d      = '0;
          state_d    = (rem_q == 16'd1) ? StAck : StData;
        end
      end
      StAck: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          o_done  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      hdr_cnt_q <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_tx_data   = (state_q == StAck) ? pk_sum : 8'h00;
  assign o_dma_addr  = addr_q;
  assign o_dma_din   = XLEN'(pk_word);
  assign o_dma_read  = 1'b0;
  assign o_busy      = (state_q != StIdle);
  assign unused_sigs = ^{i_dma_dout, pk_full};

endmodule

// File: tb/tb_uart_dma_loader.sv
// Randomised frame-level bench with a queue scoreboard for bus writes and ack bytes.
module tb_uart_dma_loader;

  localparam int unsigned Tmo = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        req;
  logic        gnt;
  logic [31:0] dma_addr;
  logic        dma_write;
  logic        dma_read;
  logic [3:0]  dma_size;
  logic [31:0] dma_din;
  logic [31:0] dma_dout;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  uart_dma_loader #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (Tmo),
    .MAGIC          (8'hA5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_req_dma   (req),
    .i_gnt_dma   (gnt),
    .o_dma_addr  (dma_addr),
    .o_dma_write (dma_write),
    .o_dma_read  (dma_read),
    .o_dma_size  (dma_size),
    .o_dma_din   (dma_din),
    .i_dma_dout  (dma_dout),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int exp_done = 0;
  int err_seen = 0;
  bit expect_err = 1'b0;
  bit drop_en = 1'b0;
  int gnt_delay = 0;
  int tx_delay = 0;
  bit gnt_block = 1'b0;
  bit gnt_force = 1'b0;

  logic [31:0] exp_waddr[$];
  logic [31:0] exp_wdata[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] payload_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, want);
    end
  endtask

  // Grant / transmitter-ready responders, updated just after each rising edge.
  int wcnt = 0;
  int tcnt = 0;
  always @(posedge clk) begin
    #2;
    if (gnt_force) gnt = 1'b1;
    else if (req && !gnt_block) begin
      gnt = (wcnt >= gnt_delay);
      wcnt++;
    end else begin
      gnt  = 1'b0;
      wcnt = 0;
    end
    if (tx_valid) begin
      tx_ready = (tcnt >= tx_delay);
      tcnt++;
    end else begin
      tx_ready = 1'b0;
      tcnt     = 0;
    end
  end

  // Monitor: samples on the falling edge what the next rising edge will commit.
  logic        prev_w = 1'b0;
  logic        prev_t = 1'b0;
  logic [31:0] pa, pd, ea, ed;
  logic [7:0]  pt, et;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_w = 1'b0;
      prev_t = 1'b0;
    end else begin
      if (req) begin
        check("rx_ready_in_write", rx_ready, 0);
        if (prev_w) begin
          check("addr_stable", dma_addr, pa);
          check("din_stable", dma_din, pd);
        end
        if (gnt) begin
          if (exp_waddr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                     dma_addr, dma_din);
          end else begin
            ea = exp_waddr.pop_front();
            ed = exp_wdata.pop_front();
            check("write_addr", dma_addr, ea);
            check("write_data", dma_din, ed);
            check("write_size", dma_size, 4'hF);
            check("write_strobes", {dma_write, dma_read}, 2'b10);
          end
          prev_w = 1'b0;
        end else begin
          prev_w = 1'b1;
          pa     = dma_addr;
          pd     = dma_din;
        end
      end else begin
        prev_w = 1'b0;
        check("idle_bus_strobes", {dma_write, dma_read, dma_size}, 0);
      end

      if (tx_valid) begin
        if (prev_t) check("tx_data_stable", tx_data, pt);
        if (tx_ready) begin
          if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tx: got 0x%02h, required no ack byte", tx_data);
          end else begin
            et = exp_tx.pop_front();
            check("tx_byte", tx_data, et);
          end
          check("done_on_accept", done, 1);
          done_seen++;
          prev_t = 1'b0;
        end else begin
          check("done_while_waiting", done, 0);
          prev_t = 1'b1;
          pt     = tx_data;
        end
      end else begin
        prev_t = 1'b0;
        if (done) begin
          tests++;
          fails++;
          $display("FAIL stray_done: got done=1 without ack accept, required 0");
        end
      end

      if (error) begin
        err_seen++;
        check("error_expected", expect_err, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   n;
    int   g;
    logic acc;
    n        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #2;
      if (acc) break;
      n++;
      if (n > 2000) begin
        tests++;
        fails++;
        $display("FAIL rx_accept_bound: byte 0x%02h not accepted within 2000 cycles", b);
        break;
      end
    end
    rx_valid = 1'b0;
    g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
    repeat (g) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: expected writes are base+4*i with payload words, ack is byte sum.
  task automatic send_frame(input logic [31:0] addr, input int len, input bit push,
                            input int stall_at);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [31:0] w;
    logic [31:0] base;
    logic [15:0] l16;
    l16   = 16'(len);
    sum   = 8'h00;
    base  = addr & 32'hFFFF_FFFC;
    bytes = {8'hA5, addr[7:0], addr[15:8], addr[23:16], addr[31:24], l16[7:0], l16[15:8]};
    for (int i = 0; i < len; i++) begin
      w = (payload_q.size() != 0) ? payload_q.pop_front() : $urandom;
      bytes.push_back(w[7:0]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[31:24]);
      sum = 8'((sum + w[7:0] + w[15:8] + w[23:16] + w[31:24]) % 256);
      if (push) begin
        exp_waddr.push_back(base + 32'(4 * i));
        exp_wdata.push_back(w);
      end
    end
    if (push) begin
      exp_tx.push_back(sum);
      exp_done++;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], (i == stall_at) ? Tmo - 2 : -1);
      if (i == 0 && drop_en) enable = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < exp_done && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("frame_done_count", done_seen, exp_done);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a;
    rst_n    = 1'b0;
    enable   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    gnt      = 1'b0;
    tx_ready = 1'b0;
    dma_dout = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_req", req, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_done_error", {done, error}, 0);
    check("reset_bus", {dma_write, dma_read, dma_size}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single word, grant always available.
    payload_q = {32'h1234_5678};
    send_frame(32'h4000_0000, 1, 1'b1, -1);
    wait_done();

    // Three words, unaligned base, grant withheld 5 cycles.
    gnt_delay = 5;
    send_frame(32'h1000_0002, 3, 1'b1, -1);
    wait_done();
    gnt_delay = 0;

    // Garbage before a zero-length frame.
    send_byte(8'h00, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h5A, -1);
    check("garbage_not_busy", busy, 0);
    send_frame($urandom, 0, 1'b1, -1);
    wait_done();

    // Header timeout then recovery.
    expect_err = 1'b1;
    send_byte(8'hA5, -1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), -1);
    repeat (Tmo + 4) begin
      @(posedge clk);
      #2;
    end
    check("timeout_error_pulses", err_seen, 1);
    check("timeout_not_busy", busy, 0);
    expect_err = 1'b0;
    send_frame($urandom, 2, 1'b1, -1);
    wait_done();

    // Stall just short of the timeout must not abort.
    send_frame($urandom, 1, 1'b1, 3);
    wait_done();

    // Transmitter back-pressure.
    tx_delay = 10;
    send_frame($urandom, 1, 1'b1, -1);
    wait_done();
    tx_delay = 0;

    // Disabled loader ignores bytes in IDLE.
    enable   = 1'b0;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("disabled_rx_ready", rx_ready, 0);
    end
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    check("disabled_not_busy", busy, 0);
    enable = 1'b1;

    // Enable dropped mid-frame does not abort.
    drop_en = 1'b1;
    send_frame($urandom, 2, 1'b1, -1);
    wait_done();
    drop_en = 1'b0;
    enable  = 1'b1;

    // Random frames, including address wrap near the top of memory.
    for (int k = 0; k < 25; k++) begin
      gnt_delay = $urandom_range(4, 0);
      tx_delay  = $urandom_range(3, 0);
      a = (k % 5 == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(3, 0))) : $urandom;
      send_frame(a, $urandom_range(4, 0), 1'b1, -1);
      wait_done();
    end
    gnt_delay = 0;
    tx_delay  = 0;

    // Reset while waiting for grant.
    gnt_block = 1'b1;
    send_frame($urandom, 1, 1'b0, -1);
    n = 0;
    while (!req && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("reset_test_req_seen", req, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("req_async_drop", req, 0);
    check("busy_async_drop", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    gnt_block = 1'b0;
    gnt_force = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_req_after_reset", req, 0);
    end
    gnt_force = 1'b0;
    @(posedge clk);
    #2;
    send_frame($urandom, 2, 1'b1, -1);
    wait_done();

    check("write_queue_empty", exp_waddr.size(), 0);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("total_errors", err_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
